// File: rtl/ni_inject_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : ni_inject_alloc
//  Description : Injection-side VC and link allocator between a network
//                interface and the local router input link. One packet at a
//                time owns a VC. A VC is only handed out when its downstream
//                buffer is completely empty, so packets never share a buffer.
//                Flits are then granted onto the link one at a time, with a
//                per-VC credit counter that tracks free downstream slots.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1               clock
//    rst_n          in   1               asynchronous active-low reset
//    Request_VA     in   NUM_VC          VC allocation request from the NI
//    Request_SA     in   NUM_VC          link request from the NI
//    Flit           in   FLIT_SIZE       NI buffered flit
//    FlitType       in   FLIT_TYPE_SIZE  type code of Flit
//    BroadcastFlit  in   1               broadcast flag of Flit
//    CreditIn       in   NUM_VC          credit return pulse per VC
//    Grant_VA       out  NUM_VC          one-hot VC grant pulse
//    Grant_SA       out  NUM_VC          one-hot link grant pulse
//    FlitOut        out  FLIT_SIZE       link flit
//    FlitTypeOut    out  FLIT_TYPE_SIZE  link flit type
//    BroadcastOut   out  1               link broadcast flag
//    FlitValidOut   out  1               link flit valid
//    VcOut          out  NUM_VC          one-hot VC of the link flit
//    CreditErr      out  1               sticky credit-overflow flag
// ============================================================================
module ni_inject_alloc #(
  parameter int FLIT_SIZE      = 64,
  parameter int FLIT_TYPE_SIZE = 2,
  parameter int NUM_VC         = 2,
  parameter int BUF_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_VC-1:0]         Request_VA,
  input  logic [NUM_VC-1:0]         Request_SA,
  input  logic [FLIT_SIZE-1:0]      Flit,
  input  logic [FLIT_TYPE_SIZE-1:0] FlitType,
  input  logic                      BroadcastFlit,
  input  logic [NUM_VC-1:0]         CreditIn,
  output logic [NUM_VC-1:0]         Grant_VA,
  output logic [NUM_VC-1:0]         Grant_SA,
  output logic [FLIT_SIZE-1:0]      FlitOut,
  output logic [FLIT_TYPE_SIZE-1:0] FlitTypeOut,
  output logic                      BroadcastOut,
  output logic                      FlitValidOut,
  output logic [NUM_VC-1:0]         VcOut,
  output logic                      CreditErr
);

  localparam int VCW  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int VCW1 = VCW + 1;
  localparam int CW   = $clog2(BUF_DEPTH + 1);

  // Flit type codes of the network common header:
  // header = 0, body = 1, tail = 2, header_tail = 3.
  localparam logic [FLIT_TYPE_SIZE-1:0] c_FT_TAIL        = FLIT_TYPE_SIZE'(2);
  localparam logic [FLIT_TYPE_SIZE-1:0] c_FT_HEADER_TAIL = FLIT_TYPE_SIZE'(3);
  localparam logic [CW-1:0]             c_CREDIT_FULL    = CW'(BUF_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [VCW-1:0]      r_cur_vc;
  logic [VCW-1:0]      w_cur_vc_nxt;
  logic [VCW-1:0]      r_rr_ptr;       // highest-priority VC for the next VA
  logic [VCW-1:0]      w_rr_ptr_nxt;
  logic [NUM_VC-1:0]   r_owned;
  logic [NUM_VC-1:0]   w_owned_nxt;
  logic [NUM_VC-1:0]   r_grant_va;
  logic [NUM_VC-1:0]   w_grant_va_nxt;
  logic [NUM_VC-1:0]   r_grant_sa;
  logic [NUM_VC-1:0]   w_grant_sa_nxt;

  logic [FLIT_SIZE-1:0]      r_flit;
  logic [FLIT_TYPE_SIZE-1:0] r_flit_type;
  logic                      r_bcast;
  logic                      r_flit_valid;
  logic [NUM_VC-1:0]         r_vc_out;
  logic                      r_credit_err;

  logic [CW-1:0]       w_credit [NUM_VC];
  logic [NUM_VC-1:0]   w_credit_ovf;
  logic [NUM_VC-1:0]   w_credit_ok;
  logic [NUM_VC-1:0]   w_eligible;
  logic [NUM_VC-1:0]   w_va_req;

  logic                w_va_found;
  logic [VCW-1:0]      w_va_pick;
  logic [VCW1-1:0]     w_rr_sum;
  logic [VCW-1:0]      w_rr_cand;

  logic [NUM_VC-1:0]   w_cur_onehot;
  logic [NUM_VC-1:0]   w_pick_onehot;
  logic                w_flit_fire;
  logic                w_release;

  // --------------------------------------------------------------------------
  // Per-VC credit counters. The decrement belongs to the cycle in which the
  // link grant is visible, i.e. the cycle whose closing edge launches the flit.
  // --------------------------------------------------------------------------
  for (genvar v = 0; v < NUM_VC; v++) begin : g_credit
    logic [CW-1:0] r_cnt;
    logic          w_dec;
    logic          w_inc;

    assign w_dec = r_grant_sa[v];
    assign w_inc = CreditIn[v];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= c_CREDIT_FULL;
      end else if (w_inc && !w_dec) begin
        // A return into a full counter is dropped; the error flag records it.
        if (r_cnt != c_CREDIT_FULL) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end

    assign w_credit[v]     = r_cnt;
    assign w_credit_ovf[v] = w_inc && !w_dec && (r_cnt == c_CREDIT_FULL);
    // A credit arriving this cycle is usable immediately, so a stalled packet
    // resumes on the cycle right after the return pulse.
    assign w_credit_ok[v]  = (r_cnt != '0) || w_inc;
    // Only an empty downstream buffer may be handed to a new packet.
    assign w_eligible[v]   = !r_owned[v] && (r_cnt == c_CREDIT_FULL);
  end

  assign w_va_req = Request_VA & w_eligible;

  // --------------------------------------------------------------------------
  // Round-robin pick among requested, eligible VCs starting at r_rr_ptr.
  // --------------------------------------------------------------------------
  always_comb begin : p_rr_pick
    w_va_found = 1'b0;
    w_va_pick  = '0;
    w_rr_sum   = '0;
    w_rr_cand  = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      w_rr_sum = {1'b0, r_rr_ptr} + VCW1'(i);
      if (w_rr_sum >= VCW1'(NUM_VC)) begin
        w_rr_sum = w_rr_sum - VCW1'(NUM_VC);
      end
      w_rr_cand = w_rr_sum[VCW-1:0];
      if (!w_va_found && w_va_req[w_rr_cand]) begin
        w_va_found = 1'b1;
        w_va_pick  = w_rr_cand;
      end
    end
  end

  assign w_cur_onehot  = NUM_VC'(1) << r_cur_vc;
  assign w_pick_onehot = NUM_VC'(1) << w_va_pick;

  // The flit presented while Grant_SA is high is the one sent on the link.
  assign w_flit_fire = |r_grant_sa;
  assign w_release   = w_flit_fire &&
                       ((FlitType == c_FT_TAIL) || (FlitType == c_FT_HEADER_TAIL));

  // --------------------------------------------------------------------------
  // Control FSM: next state and next grant values.
  // --------------------------------------------------------------------------
  always_comb begin : p_fsm_next
    w_state_nxt    = r_state;
    w_cur_vc_nxt   = r_cur_vc;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owned_nxt    = r_owned;
    w_grant_va_nxt = '0;
    w_grant_sa_nxt = '0;

    case (r_state)
      ST_IDLE: begin
        if (!(|r_grant_va) && w_va_found) begin
          w_grant_va_nxt = w_pick_onehot;
          w_cur_vc_nxt   = w_va_pick;
          w_owned_nxt    = r_owned | w_pick_onehot;
          w_rr_ptr_nxt   = (w_va_pick == VCW'(NUM_VC - 1)) ? '0 : w_va_pick + VCW'(1);
          w_state_nxt    = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        // No grant while one is showing: at most one flit every two cycles.
        if (Request_SA[r_cur_vc] && !(|r_grant_sa) && w_credit_ok[r_cur_vc]) begin
          w_grant_sa_nxt = w_cur_onehot;
        end
        if (w_release) begin
          w_owned_nxt = r_owned & ~w_cur_onehot;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and control registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cur_vc   <= '0;
      r_rr_ptr   <= '0;
      r_owned    <= '0;
      r_grant_va <= '0;
      r_grant_sa <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_vc   <= w_cur_vc_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owned    <= w_owned_nxt;
      r_grant_va <= w_grant_va_nxt;
      r_grant_sa <= w_grant_sa_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Link output registers. Payload holds between flits; valid and VC pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flit       <= '0;
      r_flit_type  <= '0;
      r_bcast      <= 1'b0;
      r_flit_valid <= 1'b0;
      r_vc_out     <= '0;
      r_credit_err <= 1'b0;
    end else begin
      if (w_flit_fire) begin
        r_flit      <= Flit;
        r_flit_type <= FlitType;
        r_bcast     <= BroadcastFlit;
      end
      r_flit_valid <= w_flit_fire;
      r_vc_out     <= r_grant_sa;
      r_credit_err <= r_credit_err | (|w_credit_ovf);
    end
  end

  assign Grant_VA     = r_grant_va;
  assign Grant_SA     = r_grant_sa;
  assign FlitOut      = r_flit;
  assign FlitTypeOut  = r_flit_type;
  assign BroadcastOut = r_bcast;
  assign FlitValidOut = r_flit_valid;
  assign VcOut        = r_vc_out;
  assign CreditErr    = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_ni_inject_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ni_inject_alloc
//  Description : Self-checking bench for ni_inject_alloc. Directed packet
//                scenarios followed by random traffic, all compared every
//                cycle against a cycle-level behavioural model of the
//                allocator rules.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports       : none (top-level bench)
// ============================================================================
module tb_ni_inject_alloc;

  localparam int FLIT_SIZE      = 64;
  localparam int FLIT_TYPE_SIZE = 2;
  localparam int NUM_VC         = 2;
  localparam int BUF_DEPTH      = 4;

  localparam logic [1:0] FT_H  = 2'd0;
  localparam logic [1:0] FT_B  = 2'd1;
  localparam logic [1:0] FT_T  = 2'd2;
  localparam logic [1:0] FT_HT = 2'd3;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_VC-1:0]         Request_VA;
  logic [NUM_VC-1:0]         Request_SA;
  logic [FLIT_SIZE-1:0]      Flit;
  logic [FLIT_TYPE_SIZE-1:0] FlitType;
  logic                      BroadcastFlit;
  logic [NUM_VC-1:0]         CreditIn;
  logic [NUM_VC-1:0]         Grant_VA;
  logic [NUM_VC-1:0]         Grant_SA;
  logic [FLIT_SIZE-1:0]      FlitOut;
  logic [FLIT_TYPE_SIZE-1:0] FlitTypeOut;
  logic                      BroadcastOut;
  logic                      FlitValidOut;
  logic [NUM_VC-1:0]         VcOut;
  logic                      CreditErr;

  ni_inject_alloc #(
    .FLIT_SIZE     (FLIT_SIZE),
    .FLIT_TYPE_SIZE(FLIT_TYPE_SIZE),
    .NUM_VC        (NUM_VC),
    .BUF_DEPTH     (BUF_DEPTH)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Request_VA   (Request_VA),
    .Request_SA   (Request_SA),
    .Flit         (Flit),
    .FlitType     (FlitType),
    .BroadcastFlit(BroadcastFlit),
    .CreditIn     (CreditIn),
    .Grant_VA     (Grant_VA),
    .Grant_SA     (Grant_SA),
    .FlitOut      (FlitOut),
    .FlitTypeOut  (FlitTypeOut),
    .BroadcastOut (BroadcastOut),
    .FlitValidOut (FlitValidOut),
    .VcOut        (VcOut),
    .CreditErr    (CreditErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: what each output should show in the current cycle.
  // --------------------------------------------------------------------------
  int          m_credit [NUM_VC];
  bit          m_active;      // a packet owns VC m_cur
  int          m_cur;
  int          m_rr;          // VC searched first on the next allocation
  bit          m_err;
  int          m_gva;         // granted VC this cycle, -1 for none
  bit          m_gsa;         // link grant showing this cycle (on m_cur)
  bit          m_fv;
  int          m_vc;
  logic [63:0] m_flit;
  logic [1:0]  m_ft;
  logic        m_bc;

  task automatic model_reset();
    for (int v = 0; v < NUM_VC; v++) m_credit[v] = BUF_DEPTH;
    m_active = 0; m_cur = 0; m_rr = 0; m_err = 0;
    m_gva = -1; m_gsa = 0; m_fv = 0; m_vc = 0;
    m_flit = '0; m_ft = '0; m_bc = 1'b0;
  endtask

  task automatic model_step(input logic [NUM_VC-1:0] va, input logic [NUM_VC-1:0] sa,
                            input logic [NUM_VC-1:0] cin, input logic [1:0] ft,
                            input logic [63:0] fl, input logic bc);
    int n_credit [NUM_VC];
    bit n_active;
    int n_cur;
    int n_rr;
    int n_gva;
    bit n_gsa;
    bit dec;
    n_active = m_active; n_cur = m_cur; n_rr = m_rr;
    n_gva = -1; n_gsa = 0;

    // Credits: a flit sent consumes one, a return gives one back,
    // a return that would exceed the buffer depth is an error.
    for (int v = 0; v < NUM_VC; v++) begin
      dec = m_gsa && (m_cur == v);
      n_credit[v] = m_credit[v];
      if (cin[v] && !dec) begin
        if (m_credit[v] == BUF_DEPTH) m_err = 1;
        else n_credit[v] = m_credit[v] + 1;
      end else if (dec && !cin[v]) begin
        n_credit[v] = m_credit[v] - 1;
      end
    end

    // Link: the flit presented during a grant cycle appears next cycle.
    if (m_gsa) begin
      m_flit = fl; m_ft = ft; m_bc = bc; m_vc = m_cur;
      if (ft == FT_T || ft == FT_HT) n_active = 0;
    end
    m_fv = m_gsa;

    // Next link grant.
    if (m_active && sa[m_cur] && !m_gsa && (m_credit[m_cur] > 0 || cin[m_cur]))
      n_gsa = 1;

    // Next VC grant: round-robin over fully credited requested VCs.
    if (!m_active && va != '0) begin
      for (int i = 0; i < NUM_VC; i++) begin
        int idx;
        idx = (m_rr + i) % NUM_VC;
        if (n_gva < 0 && va[idx] && m_credit[idx] == BUF_DEPTH) begin
          n_gva    = idx;
          n_cur    = idx;
          n_active = 1;
          n_rr     = (idx + 1) % NUM_VC;
        end
      end
    end

    for (int v = 0; v < NUM_VC; v++) m_credit[v] = n_credit[v];
    m_active = n_active; m_cur = n_cur; m_rr = n_rr;
    m_gva = n_gva; m_gsa = n_gsa;
  endtask

  task automatic check_all();
    logic [NUM_VC-1:0] e_gva;
    logic [NUM_VC-1:0] e_gsa;
    logic [NUM_VC-1:0] e_vc;
    e_gva = (m_gva < 0) ? '0 : (NUM_VC'(1) << m_gva);
    e_gsa = m_gsa ? (NUM_VC'(1) << m_cur) : '0;
    e_vc  = m_fv ? (NUM_VC'(1) << m_vc) : '0;
    chk("Grant_VA", Grant_VA, e_gva);
    chk("Grant_SA", Grant_SA, e_gsa);
    chk("FlitValidOut", FlitValidOut, m_fv);
    chk("VcOut", VcOut, e_vc);
    chk("FlitOut", FlitOut, m_flit);
    chk("FlitTypeOut", FlitTypeOut, m_ft);
    chk("BroadcastOut", BroadcastOut, m_bc);
    chk("CreditErr", CreditErr, m_err);
  endtask

  // One clock cycle: drive after a falling edge, check at the next one.
  task automatic cyc(input logic [NUM_VC-1:0] va, input logic [NUM_VC-1:0] sa,
                     input logic [NUM_VC-1:0] cin, input logic [1:0] ft,
                     input logic [63:0] fl, input logic bc);
    Request_VA = va; Request_SA = sa; CreditIn = cin;
    FlitType = ft; Flit = fl; BroadcastFlit = bc;
    model_step(va, sa, cin, ft, fl, bc);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, '0, FT_H, 64'h0, 1'b0);
  endtask

  // Pulls reset low between edges, checks outputs at once, releases on the
  // next falling edge. Called right after a falling edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int last_pulse;
    int idx;
    logic [1:0] ft;
    n_checks = 0;
    n_fail   = 0;
    Request_VA = '0; Request_SA = '0; CreditIn = '0;
    Flit = '0; FlitType = '0; BroadcastFlit = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #3 check_all();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Single header_tail flit on VC0.
    cyc(2'b11, 2'b00, 2'b00, FT_HT, 64'h1111, 1'b1);
    chk("single_grant_va", Grant_VA, 2'b01);
    cyc(2'b00, 2'b01, 2'b00, FT_HT, 64'h1111, 1'b1);
    chk("single_grant_sa", Grant_SA, 2'b01);
    cyc(2'b00, 2'b00, 2'b00, FT_HT, 64'h1111, 1'b1);
    chk("single_valid", FlitValidOut, 1'b1);
    chk("single_vcout", VcOut, 2'b01);
    chk("single_flit", FlitOut, 64'h1111);
    cyc(2'b01, 2'b00, 2'b00, FT_H, 64'h0, 1'b0);
    chk("valid_drops", FlitValidOut, 1'b0);
    chk("flit_holds", FlitOut, 64'h1111);
    chk("vc0_partial_no_grant", Grant_VA, 2'b00);
    cyc(2'b00, 2'b00, 2'b01, FT_H, 64'h0, 1'b0);

    // Round-robin.
    cyc(2'b11, 2'b00, 2'b00, FT_H, 64'h0, 1'b0);
    chk("rr_second_vc1", Grant_VA, 2'b10);
    cyc(2'b00, 2'b10, 2'b00, FT_HT, 64'h2222, 1'b0);
    cyc(2'b00, 2'b00, 2'b00, FT_HT, 64'h2222, 1'b0);
    chk("rr_second_vcout", VcOut, 2'b10);
    cyc(2'b11, 2'b00, 2'b00, FT_H, 64'h0, 1'b0);
    chk("rr_third_vc0", Grant_VA, 2'b01);
    cyc(2'b00, 2'b01, 2'b00, FT_HT, 64'h3333, 1'b1);
    cyc(2'b00, 2'b00, 2'b00, FT_HT, 64'h3333, 1'b1);
    cyc(2'b00, 2'b00, 2'b11, FT_H, 64'h0, 1'b0);

    // Credit stall: five-flit packet on VC0 with no returns.
    cyc(2'b01, 2'b00, 2'b00, FT_H, 64'h0, 1'b0);
    chk("stall_grant_va", Grant_VA, 2'b01);
    pulses = 0;
    last_pulse = -10;
    for (int c = 0; c < 14; c++) begin
      idx = (Grant_SA != '0) ? pulses - 1 : pulses;
      ft  = (idx == 0) ? FT_H : ((idx == 4) ? FT_T : FT_B);
      cyc(2'b00, (pulses < 5) ? 2'b01 : 2'b00, 2'b00, ft, 64'h5000 + 64'(idx), 1'b0);
      if (Grant_SA != '0) begin
        pulses++;
        if (pulses > 1) chk("stall_spacing", 64'(c - last_pulse), 64'd2);
        last_pulse = c;
      end
    end
    chk("stall_pulses", 64'(pulses), 64'd4);
    cyc(2'b00, 2'b01, 2'b01, FT_T, 64'h5004, 1'b0);
    chk("stall_resume", Grant_SA, 2'b01);
    cyc(2'b00, 2'b00, 2'b00, FT_T, 64'h5004, 1'b0);
    chk("stall_tail_type", FlitTypeOut, FT_T);
    for (int i = 0; i < 4; i++) cyc(2'b00, 2'b00, 2'b01, FT_H, 64'h0, 1'b0);

    // Simultaneous send and return on VC0 leaves it full.
    cyc(2'b01, 2'b00, 2'b00, FT_H, 64'h0, 1'b0);
    cyc(2'b00, 2'b01, 2'b00, FT_HT, 64'h6666, 1'b1);
    cyc(2'b00, 2'b00, 2'b01, FT_HT, 64'h6666, 1'b1);
    cyc(2'b01, 2'b00, 2'b00, FT_H, 64'h0, 1'b0);
    chk("simul_unchanged", Grant_VA, 2'b01);
    cyc(2'b00, 2'b01, 2'b00, FT_HT, 64'h7777, 1'b0);
    cyc(2'b00, 2'b00, 2'b00, FT_HT, 64'h7777, 1'b0);
    cyc(2'b00, 2'b00, 2'b01, FT_H, 64'h0, 1'b0);
    chk("err_clear", CreditErr, 1'b0);
    cyc(2'b00, 2'b00, 2'b01, FT_H, 64'h0, 1'b0);
    chk("err_set", CreditErr, 1'b1);
    idle(3);
    chk("err_hold", CreditErr, 1'b1);

    // Reset in the middle of a packet.
    cyc(2'b10, 2'b00, 2'b00, FT_H, 64'h0, 1'b0);
    chk("mid_grant_va", Grant_VA, 2'b10);
    cyc(2'b00, 2'b10, 2'b00, FT_H, 64'h8888, 1'b1);
    chk("mid_grant_sa", Grant_SA, 2'b10);
    async_reset();
    chk("rst_no_flit", FlitValidOut, 1'b0);
    chk("rst_err_clear", CreditErr, 1'b0);
    cyc(2'b00, 2'b10, 2'b00, FT_H, 64'h9999, 1'b0);
    chk("rst_sa_ignored", Grant_SA, 2'b00);
    cyc(2'b10, 2'b00, 2'b00, FT_H, 64'h0, 1'b0);
    chk("rst_vc1_full", Grant_VA, 2'b10);
    cyc(2'b00, 2'b10, 2'b00, FT_HT, 64'hAAAA, 1'b0);
    cyc(2'b00, 2'b00, 2'b00, FT_HT, 64'hAAAA, 1'b0);
    cyc(2'b00, 2'b00, 2'b10, FT_H, 64'h0, 1'b0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        cyc(NUM_VC'($urandom_range(0, 3)), NUM_VC'($urandom_range(0, 3)),
            {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
            2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
